fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset; bits [1:0] are treated as 0.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-004 The block SHALL have port imem_req, output, 1, instruction memory request valid.
REQ-005 The block SHALL have port imem_addr, output, 32, request word address; bits [1:0] always 0.
REQ-006 The block SHALL have port imem_gnt, input, 1, request accepted this cycle when high with imem_req.
REQ-007 The block SHALL have ports imem_rvalid (input, 1) and imem_rdata (input, 32), the response valid and its data, arriving at least 1 cycle after grant.
REQ-008 The block SHALL have ports redirect (input, 1) and redirect_pc (input, 32), the taken branch/jump target from execute.
REQ-009 The block SHALL have ports instr_valid (output, 1), instr (output, 32) and instr_pc (output, 32), the instruction offered to decode and its address.
REQ-010 The block SHALL have port instr_ready, input, 1, decode accepts instr when high with instr_valid.
REQ-011 The block SHALL have port fetch_count, output, 32, count of instructions delivered to decode.

Function
REQ-012 The block SHALL implement the states IDLE, FETCH, WAIT and HOLD, with at most one memory request outstanding.
REQ-013 IDLE SHALL move to FETCH unconditionally on the first clock edge after reset release; imem_req=0.
REQ-014 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal fetch_pc.
REQ-015 In FETCH on imem_gnt: pend_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0), next state WAIT.
REQ-016 In FETCH without imem_gnt, the block SHALL hold state and address.
REQ-017 In WAIT, imem_req SHALL be 0; on imem_rvalid with squash=0: instr<=imem_rdata, instr_pc<=pend_pc, instr_valid<=1, next state HOLD.
REQ-018 In WAIT on imem_rvalid with squash=1, the block SHALL discard the data, clear squash and go to FETCH; outputs unchanged.
REQ-019 In HOLD, instr_valid SHALL be 1 and instr and instr_pc SHALL be stable; on instr_ready: instr_valid<=0, fetch_count<=fetch_count+1 (wraps), next state FETCH.
REQ-020 A redirect SHALL take priority over all other events; the target used is {redirect_pc[31:2],2'b00}.
REQ-021 Redirect in IDLE or FETCH without gnt: fetch_pc<=target, state unchanged apart from the IDLE->FETCH step.
REQ-022 Redirect in FETCH coincident with gnt: fetch_pc<=target, squash<=1, next WAIT, so the granted old response is dropped.
REQ-023 Redirect in WAIT: fetch_pc<=target; with rvalid in the same cycle the data SHALL be dropped and the next state SHALL be FETCH; otherwise squash<=1.
REQ-024 Redirect in HOLD: instr_valid<=0 and fetch_pc<=target, next FETCH; fetch_count SHALL NOT increment even if instr_ready is high.
REQ-025 imem_rvalid outside WAIT is a protocol violation and SHALL be ignored.
REQ-026 imem_req and instr_valid SHALL be decoded from registered state only, with no combinational path from inputs.

Reset
REQ-027 Asserting rst_n=0 SHALL immediately set: state=IDLE, fetch_pc=RESET_PC, pend_pc=0, squash=0, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, fetch_count=0.
REQ-028 Reset mid-transaction SHALL abandon any outstanding request; responses after release SHALL be ignored until a new grant.

Verification
REQ-029 Reset release, gnt in the first FETCH cycle, rvalid 2 cycles later with 32'h00500093, ready=1 -> instr_valid with instr=32'h00500093 and instr_pc=0; next request addr=4; fetch_count=1.
REQ-030 Decode backpressure: ready=0 for 5 cycles in HOLD -> instr and instr_pc stable, imem_req=0 and fetch_count constant; ready=1 -> one increment, then FETCH.
REQ-031 Redirect to 32'h0000_0103 coincident with gnt at addr 8 -> old response dropped, next imem_addr=32'h0000_0100, and the delivered instr_pc is 32'h100.
REQ-032 Redirect in HOLD with ready=1 at the same time -> no delivery counted, instr_valid=0 the next cycle, and fetch resumes at the target.
REQ-033 With RESET_PC=32'hFFFF_FFFC, fetch two instructions -> instr_pc values FFFF_FFFC then 0000_0000.
REQ-034 Assert rst_n in WAIT, then after release issue a stray rvalid before any grant -> ignored, instr_valid stays 0, and the first fetch is RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: single-outstanding instruction fetch FSM that feeds decode
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   imem_req, imem_addr         request to instruction memory (word aligned)
//   imem_gnt                    memory accepted the request this cycle
//   imem_rvalid, imem_rdata     memory response, at least one cycle after grant
//   redirect, redirect_pc       taken branch/jump target from execute
//   instr_valid, instr, instr_pc  instruction offered to decode and its address
//   instr_ready                 decode accepts the offered instruction
//   fetch_count                 number of instructions accepted by decode
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic [31:0] fetch_count
);
    typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_t;

    localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};

    state_t      r_state, w_state;
    logic [31:0] r_fetch_pc, w_fetch_pc;
    logic [31:0] r_pend_pc, w_pend_pc;
    logic [31:0] r_instr, w_instr;
    logic [31:0] r_instr_pc, w_instr_pc;
    logic [31:0] r_count, w_count;
    logic        r_squash, w_squash;
    logic [31:0] w_target;

    assign w_target = {redirect_pc[31:2], 2'b00};

    // Redirect is tested first in every state so it wins over gnt, rvalid and ready.
    // r_squash marks a granted request whose response must be thrown away.
    always_comb begin
        w_state    = r_state;
        w_fetch_pc = r_fetch_pc;
        w_pend_pc  = r_pend_pc;
        w_instr    = r_instr;
        w_instr_pc = r_instr_pc;
        w_count    = r_count;
        w_squash   = r_squash;
        case (r_state)
            IDLE: begin
                w_state    = FETCH;
                w_fetch_pc = redirect ? w_target : r_fetch_pc;
            end
            FETCH: begin
                if (redirect) begin
                    w_fetch_pc = w_target;
                    if (imem_gnt) begin
                        w_squash = 1'b1;
                        w_state  = WAIT;
                    end
                end else if (imem_gnt) begin
                    w_pend_pc  = r_fetch_pc;
                    w_fetch_pc = r_fetch_pc + 32'd4;
                    w_state    = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    // A response arriving with the redirect retires the request;
                    // otherwise the still-outstanding response must be dropped later.
                    w_fetch_pc = w_target;
                    w_squash   = !imem_rvalid;
                    w_state    = imem_rvalid ? FETCH : WAIT;
                end else if (imem_rvalid) begin
                    if (r_squash) begin
                        w_squash = 1'b0;
                        w_state  = FETCH;
                    end else begin
                        w_instr    = imem_rdata;
                        w_instr_pc = r_pend_pc;
                        w_state    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    w_fetch_pc = w_target;
                    w_state    = FETCH;
                end else if (instr_ready) begin
                    w_count = r_count + 32'd1;
                    w_state = FETCH;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_fetch_pc <= START_PC;
            r_pend_pc  <= '0;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_count    <= '0;
            r_squash   <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_fetch_pc <= w_fetch_pc;
            r_pend_pc  <= w_pend_pc;
            r_instr    <= w_instr;
            r_instr_pc <= w_instr_pc;
            r_count    <= w_count;
            r_squash   <= w_squash;
        end
    end

    // Handshake outputs depend on the state register only.
    assign imem_req    = (r_state == FETCH);
    assign instr_valid = (r_state == HOLD);
    assign imem_addr   = r_fetch_pc;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign fetch_count = r_count;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage with a memory responder and a PC-stream model
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req, imem_gnt, imem_rvalid, redirect, instr_valid, instr_ready;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc, fetch_count;
    logic        w1_req, w1_iv;
    logic [31:0] w1_addr, w1_instr, w1_ipc, w1_cnt;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_pc, m_fa, n_del;
    logic        k_gnt, k_rdy, k_redir, k_stray;
    logic [31:0] k_tgt;
    int          k_lat;
    logic        out_pend;
    int          lat_cnt;
    logic [31:0] out_addr;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .fetch_count(fetch_count)
    );

    // Same stimulus, start address just below the 32-bit wrap point.
    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w1_req), .imem_addr(w1_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(w1_iv), .instr(w1_instr), .instr_pc(w1_ipc),
        .instr_ready(instr_ready), .fetch_count(w1_cnt)
    );

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return 32'h0050_0093 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    // One clock: memory response, model update, drive inputs, advance past the edge.
    task automatic tick();
        logic        rv = 1'b0;
        logic [31:0] rd = $urandom;
        if (out_pend && lat_cnt == 0) begin
            rv       = 1'b1;
            rd       = mem_f(out_addr);
            out_pend = 1'b0;
        end else if (out_pend) begin
            lat_cnt--;
        end else if (k_stray) begin
            rv = 1'b1;
        end
        if (imem_req && k_gnt) chk("req_addr", imem_addr, m_fa);
        if (!k_redir && instr_valid && k_rdy) begin
            exp_q.push_back(m_pc);
            m_pc += 32'd4;
            n_del++;
        end
        if (imem_req && k_gnt) begin
            out_pend = 1'b1;
            out_addr = imem_addr;
            lat_cnt  = k_lat - 1;
            m_fa += 32'd4;
        end
        if (k_redir) begin
            m_pc = {k_tgt[31:2], 2'b00};
            m_fa = m_pc;
        end
        imem_gnt    = k_gnt;
        instr_ready = k_rdy;
        redirect    = k_redir;
        redirect_pc = k_tgt;
        imem_rvalid = rv;
        imem_rdata  = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic g, input logic r, input logic d, input logic [31:0] t,
                      input int l, input logic s);
        k_gnt   = g;
        k_rdy   = r;
        k_redir = d;
        k_tgt   = t;
        k_lat   = l;
        k_stray = s;
        tick();
    endtask

    task automatic reset_dut();
        rst_n       = 1'b0;
        out_pend    = 1'b0;
        exp_q.delete();
        m_pc        = 32'h0;
        m_fa        = 32'h0;
        n_del       = 32'h0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b0;
        #1;
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_count", fetch_count, 32'h0);
        chk("rst_addr_w", w1_addr, 32'hFFFF_FFFC);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: every accepted instruction must match the next entry of the PC stream.
    initial forever begin
        logic [31:0] e;
        @(negedge clk);
        if (rst_n && instr_valid && instr_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL sb_empty: unexpected delivery pc %h", instr_pc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", instr_pc, e);
                chk("sb_instr", instr, mem_f(e));
            end
        end
    end

    initial begin
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
        out_pend = 1'b0; lat_cnt = 0; out_addr = 32'h0;
        #2;
        reset_dut();
        // first fetch after reset
        go(1, 1, 0, 0, 2, 0);
        chk("idle_to_fetch", {31'h0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, 32'h0);
        go(1, 1, 0, 0, 2, 0);
        chk("wait_no_req", {31'h0, imem_req}, 32'h0);
        go(0, 1, 0, 0, 2, 0);
        go(0, 1, 0, 0, 2, 0);
        chk("hold_valid", {31'h0, instr_valid}, 32'h1);
        chk("hold_instr", instr, 32'h0050_0093);
        chk("hold_pc", instr_pc, 32'h0);
        go(0, 1, 0, 0, 2, 0);
        chk("count_1", fetch_count, 32'h1);
        chk("next_addr", imem_addr, 32'h4);
        chk("next_req", {31'h0, imem_req}, 32'h1);
        // decode backpressure
        go(1, 0, 0, 0, 1, 0);
        go(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            go(0, 0, 0, 0, 1, 0);
            chk("bp_instr", instr, mem_f(32'h4));
            chk("bp_pc", instr_pc, 32'h4);
            chk("bp_req", {31'h0, imem_req}, 32'h0);
            chk("bp_valid", {31'h0, instr_valid}, 32'h1);
            chk("bp_count", fetch_count, 32'h1);
        end
        go(0, 1, 0, 0, 1, 0);
        chk("bp_release_count", fetch_count, 32'h2);
        chk("bp_release_addr", imem_addr, 32'h8);
        // redirect coincident with grant
        go(1, 0, 1, 32'h0000_0103, 1, 0);
        chk("sq_wait", {31'h0, imem_req}, 32'h0);
        go(0, 0, 0, 0, 1, 0);
        chk("sq_refetch", {31'h0, imem_req}, 32'h1);
        chk("sq_addr", imem_addr, 32'h100);
        chk("sq_no_valid", {31'h0, instr_valid}, 32'h0);
        go(1, 0, 0, 0, 1, 0);
        go(0, 0, 0, 0, 1, 0);
        chk("sq_pc", instr_pc, 32'h100);
        chk("sq_instr", instr, mem_f(32'h100));
        go(0, 1, 0, 0, 1, 0);
        // redirect in HOLD with ready
        go(1, 0, 0, 0, 1, 0);
        go(0, 0, 0, 0, 1, 0);
        go(0, 1, 1, 32'h200, 1, 0);
        chk("hr_valid", {31'h0, instr_valid}, 32'h0);
        chk("hr_count", fetch_count, 32'h3);
        chk("hr_addr", imem_addr, 32'h200);
        go(1, 1, 0, 0, 1, 0);
        go(0, 1, 0, 0, 1, 0);
        go(0, 1, 0, 0, 1, 0);
        chk("hr_count_after", fetch_count, 32'h4);
        // redirect in WAIT, with and without a coincident response
        go(1, 0, 0, 0, 1, 0);
        go(0, 0, 1, 32'h300, 1, 0);
        chk("wr_rv_req", {31'h0, imem_req}, 32'h1);
        chk("wr_rv_addr", imem_addr, 32'h300);
        go(1, 0, 0, 0, 2, 0);
        go(0, 0, 1, 32'h400, 1, 0);
        chk("wr_still_wait", {31'h0, imem_req}, 32'h0);
        go(0, 0, 0, 0, 1, 0);
        chk("wr_drop_addr", imem_addr, 32'h400);
        chk("wr_drop_valid", {31'h0, instr_valid}, 32'h0);
        // reset in WAIT, stray response afterwards, then wrap-around fetch
        go(1, 0, 0, 0, 2, 0);
        reset_dut();
        go(0, 0, 0, 0, 1, 1);
        go(0, 0, 0, 0, 1, 1);
        chk("stray_valid", {31'h0, instr_valid}, 32'h0);
        chk("stray_req", {31'h0, imem_req}, 32'h1);
        chk("stray_addr", imem_addr, 32'h0);
        chk("stray_addr_w", w1_addr, 32'hFFFF_FFFC);
        go(1, 1, 0, 0, 1, 0);
        go(0, 1, 0, 0, 1, 0);
        chk("wrap_valid", {31'h0, w1_iv}, 32'h1);
        chk("wrap_pc0", w1_ipc, 32'hFFFF_FFFC);
        go(1, 1, 0, 0, 1, 0);
        chk("wrap_addr", w1_addr, 32'h0);
        go(1, 1, 0, 0, 1, 0);
        go(0, 1, 0, 0, 1, 0);
        chk("wrap_pc1", w1_ipc, 32'h0);
        go(0, 1, 0, 0, 1, 0);
        chk("wrap_count", w1_cnt, 32'h2);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) reset_dut();
            k_gnt   = ($urandom_range(0, 3) != 0);
            k_rdy   = ($urandom_range(0, 9) < 7);
            k_redir = ($urandom_range(0, 11) == 0);
            k_tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            k_stray = ($urandom_range(0, 9) == 0);
            k_lat   = $urandom_range(1, 4);
            tick();
        end
        for (int i = 0; i < 12; i++) go(1, 1, 0, 0, 1, 0);
        chk("final_count", fetch_count, n_del);
        chk("final_count_w", w1_cnt, n_del);
        chk("sb_drained", exp_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
